// File: rtl/reg_arb_pkg.sv
// Shared definitions for the 4-requester round-robin register-write arbiter:
// FSM state encoding, requester count and the round-robin pick helper.
package reg_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  // Returns {found, index} of the first asserted request at or above ptr, wrapping.
  // Scanning from the far end down lets the closest match win on the last assignment.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    rr_pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) begin
        rr_pick = {1'b1, idx};
      end
    end
  endfunction

endpackage

// File: rtl/reg_ce_aset.sv
// W-bit register with clock enable and asynchronous active-high set to all-ones.
module reg_ce_aset #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         i_set,
  input  logic         i_ce,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge clk or posedge i_set) begin
    if (i_set) begin
      o_q <= '1;
    end else if (i_ce) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/reg4_rr_write_arbiter.sv
// Round-robin arbiter granting four requesters (plus a priority preset) write
// access to one shared register: IDLE -> WRITE (one CE cycle) -> ACK (one pulse).
module reg4_rr_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                 clk,
  input  logic                 R_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*W-1:0] wdata,
  input  logic                 preset_req,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 preset_ack,
  output logic                 busy,
  output logic [IDX_W-1:0]     owner,
  output logic [W-1:0]         Q
);

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_ptr, w_ptr_next;
  logic [IDX_W-1:0] r_owner, w_owner_next;
  logic             r_preset, w_preset_next;
  logic             w_ce;
  logic             w_set;
  logic [W-1:0]     w_d;
  logic [IDX_W:0]   w_pick;
  logic [W-1:0]     w_wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_wdata
      assign w_wdata_arr[gi] = wdata[gi*W +: W];
    end
  endgenerate

  assign w_pick = rr_pick(req, r_ptr);
  assign w_set  = ~R_n;

  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_preset <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_ptr    <= w_ptr_next;
      r_owner  <= w_owner_next;
      r_preset <= w_preset_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_ptr_next    = r_ptr;
    w_owner_next  = r_owner;
    w_preset_next = r_preset;
    w_ce          = 1'b0;
    w_d           = r_preset ? '1 : w_wdata_arr[r_owner];
    ack           = '0;
    preset_ack    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (preset_req) begin
          w_state_next  = ST_WRITE;
          w_preset_next = 1'b1;
          w_owner_next  = '0;
        end else if (w_pick[IDX_W]) begin
          w_state_next  = ST_WRITE;
          w_preset_next = 1'b0;
          w_owner_next  = w_pick[IDX_W-1:0];
        end
      end
      ST_WRITE: begin
        w_ce         = 1'b1;
        w_state_next = ST_ACK;
      end
      ST_ACK: begin
        // A preset leaves the round-robin pointer where it was.
        if (r_preset) begin
          preset_ack = 1'b1;
        end else begin
          ack[r_owner] = 1'b1;
          w_ptr_next   = r_owner + 1'b1;
        end
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign busy  = (r_state != ST_IDLE);
  assign owner = (busy && !r_preset) ? r_owner : '0;

  reg_ce_aset #(.W(W)) u_reg (
    .clk   (clk),
    .i_set (w_set),
    .i_ce  (w_ce),
    .i_d   (w_d),
    .o_q   (Q)
  );

endmodule

// File: tb/tb_reg4_rr_write_arbiter.sv
// Scoreboard bench for reg4_rr_write_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and compares whenever ack or preset_ack pulses.
module tb_reg4_rr_write_arbiter;

  logic        clk;
  logic        R_n;
  logic [3:0]  req;
  logic [15:0] wdata;
  logic        preset_req;
  logic [3:0]  ack;
  logic        preset_ack;
  logic        busy;
  logic [1:0]  owner;
  logic [3:0]  Q;

  typedef struct {
    bit         is_preset;
    int         idx;
    logic [3:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  reg4_rr_write_arbiter #(.W(4)) dut (
    .clk        (clk),
    .R_n        (R_n),
    .req        (req),
    .wdata      (wdata),
    .preset_req (preset_req),
    .ack        (ack),
    .preset_ack (preset_ack),
    .busy       (busy),
    .owner      (owner),
    .Q          (Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one line per completed transaction, compared against the scoreboard head.
  always @(negedge clk) begin
    if (R_n && (ack != 4'b0 || preset_ack)) begin
      exp_t e;
      logic [3:0] exp_ack;
      logic [1:0] exp_owner;
      checks++;
      if (ack != 4'b0 && preset_ack) begin
        errors++;
        $display("FAIL ack_excl: ack=%b preset_ack=%b, required not both", ack, preset_ack);
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack=%b preset_ack=%b with no pending transaction", ack, preset_ack);
      end else begin
        e         = sb.pop_front();
        exp_ack   = e.is_preset ? 4'b0 : (4'b0001 << e.idx);
        exp_owner = e.is_preset ? 2'd0 : e.idx[1:0];
        txn++;
        $display("txn %0d: ack=%b preset_ack=%b owner=%0d Q=%h (expected ack=%b preset_ack=%b owner=%0d Q=%h)",
                 txn, ack, preset_ack, owner, Q, exp_ack, e.is_preset, exp_owner, e.data);
        checks += 3;
        if (ack != exp_ack || preset_ack != e.is_preset) begin
          errors++;
          $display("FAIL ack_vec: ack=%b preset_ack=%b, required ack=%b preset_ack=%b",
                   ack, preset_ack, exp_ack, e.is_preset);
        end
        if (Q != e.data) begin
          errors++;
          $display("FAIL q_data: Q=%h, required %h", Q, e.data);
        end
        if (owner != exp_owner) begin
          errors++;
          $display("FAIL ack_owner: owner=%0d, required %0d", owner, exp_owner);
        end
      end
    end
  end

  task automatic push(input bit p, input int idx, input logic [3:0] d);
    exp_t e;
    e.is_preset = p;
    e.idx       = idx;
    e.data      = d;
    sb.push_back(e);
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for ack[idx], or preset_ack when idx==4; checks owner while busy.
  task automatic wait_ack(input int idx, input bit chk_owner, input logic [1:0] exp_owner);
    bit seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (chk_owner && busy) check4("owner_busy", {2'b0, owner}, {2'b0, exp_owner});
      seen = (idx == 4) ? preset_ack : ack[idx];
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout_ack%0d: no completion within 20 cycles, required one", idx);
    end
  endtask

  task automatic wait_busy();
    bit seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = busy;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout_busy: busy never rose, required high");
    end
  endtask

  initial begin
    R_n        = 1'b0;
    req        = 4'b0;
    wdata      = 16'h0;
    preset_req = 1'b0;
    #12;
    check4("rst_Q", Q, 4'hF);
    check4("rst_busy", {3'b0, busy}, 4'h0);
    check4("rst_ack", ack, 4'h0);
    check4("rst_preset_ack", {3'b0, preset_ack}, 4'h0);
    check4("rst_owner", {2'b0, owner}, 4'h0);
    @(posedge clk); #1 R_n = 1'b1;

    // Single write from requester 2 (ptr becomes 3).
    push(0, 2, 4'hA);
    wdata[11:8] = 4'hA;
    req[2] = 1'b1;
    wait_ack(2, 1, 2'd2);
    req[2] = 1'b0;

    // Late drop: requester 3 releases req during WRITE (ptr becomes 0).
    push(0, 3, 4'h6);
    wdata[15:12] = 4'h6;
    req[3] = 1'b1;
    wait_busy();
    req[3] = 1'b0;
    wait_ack(3, 1, 2'd3);

    // Round robin with all four held continuously from ptr 0.
    wdata = 16'h8765;
    push(0, 0, 4'h5); push(0, 1, 4'h6); push(0, 2, 4'h7); push(0, 3, 4'h8); push(0, 0, 4'h5);
    req = 4'b1111;
    begin
      int n = 0;
      for (int c = 0; c < 60 && n < 5; c++) begin
        @(negedge clk);
        if (ack != 4'b0) n++;
      end
      req = 4'b0;
      if (n < 5) begin
        checks++;
        errors++;
        $display("FAIL timeout_rr: saw %0d acks, required 5", n);
      end
    end

    // Requester 1 loads 3 (ptr becomes 2), then preset competes with requester 0.
    push(0, 1, 4'h3);
    wdata[7:4] = 4'h3;
    req[1] = 1'b1;
    wait_ack(1, 1, 2'd1);
    req[1] = 1'b0;
    push(1, 0, 4'hF);
    push(0, 0, 4'h9);
    wdata[3:0] = 4'h9;
    preset_req = 1'b1;
    req[0] = 1'b1;
    wait_ack(4, 1, 2'd0);
    preset_req = 1'b0;
    wait_ack(0, 1, 2'd0);
    req[0] = 1'b0;

    // Reset pulsed mid-WRITE for requester 1: aborted, then re-granted after release.
    wdata[7:4] = 4'hC;
    req[1] = 1'b1;
    wait_busy();
    #2 R_n = 1'b0;
    #1;
    check4("midrst_Q", Q, 4'hF);
    check4("midrst_busy", {3'b0, busy}, 4'h0);
    check4("midrst_ack", ack, 4'h0);
    @(posedge clk); #1 R_n = 1'b1;
    push(0, 1, 4'hC);
    wait_ack(1, 1, 2'd1);
    req[1] = 1'b0;

    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d transactions outstanding, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
